// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with ce-qualified sync/de delay and frame-synchronous config.
// Define VGA_TIMING_FRAMECNT_EN to build the completed-frame counter; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int              H_VIS    = 640,
  parameter int              H_FRONT  = 16,
  parameter int              H_SYNC   = 96,
  parameter int              H_BACK   = 48,
  parameter int              V_VIS    = 480,
  parameter int              V_FRONT  = 10,
  parameter int              V_SYNC   = 2,
  parameter int              V_BACK   = 33,
  parameter bit              HS_POL   = 1'b0,
  parameter bit              VS_POL   = 1'b0,
  parameter int              PIPE_DLY = 2,
  parameter int              CFG_W    = 8,
  parameter logic [CFG_W-1:0] CFG_RST = '0,
  parameter int              FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [CFG_W-1:0]   cfg_in,
  input  logic               cfg_wr,
  output logic [10:0]        x,
  output logic [9:0]         y,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [CFG_W-1:0]   cfg_out,
  output logic               cfg_pending,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = PIPE_DLY + 1;

  if (H_TOTAL > 2048) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL must not exceed 2048");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL must not exceed 1024");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be within 0..7");
  end

  // One extra bit so limits equal to 2048/1024 still compare correctly.
  localparam logic [11:0] X_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] X_VIS    = 12'(H_VIS);
  localparam logic [11:0] HS_START = 12'(H_VIS + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VIS + H_FRONT + H_SYNC);
  localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] Y_VIS    = 11'(V_VIS);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FRONT + V_SYNC);

  logic [11:0]      xe;
  logic [10:0]      ye;
  logic             hs_raw;
  logic             vs_raw;
  logic             de_raw;
  logic [DW-1:0]    hs_pipe;
  logic [DW-1:0]    vs_pipe;
  logic [DW-1:0]    de_pipe;
  logic [CFG_W-1:0] shadow;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (ce) begin
      if (xe == X_LAST) begin
        x <= '0;
        if (ye == Y_LAST) y <= '0;
        else              y <= y + 10'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  always_comb begin
    hs_raw      = (xe >= HS_START) && (xe < HS_END);
    vs_raw      = (ye >= VS_START) && (ye < VS_END);
    de_raw      = (xe < X_VIS) && (ye < Y_VIS);
    line_start  = ce && (x == '0);
    frame_start = ce && (x == '0) && (y == '0);
  end

  // Pipes hold active-high values; bit 0 is the first register, the top bit drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
      de_pipe <= '0;
    end else if (ce) begin
      hs_pipe <= DW'({hs_pipe, hs_raw});
      vs_pipe <= DW'({vs_pipe, vs_raw});
      de_pipe <= DW'({de_pipe, de_raw});
    end
  end

  assign hsync = hs_pipe[PIPE_DLY] ^ ~HS_POL;
  assign vsync = vs_pipe[PIPE_DLY] ^ ~VS_POL;
  assign de    = de_pipe[PIPE_DLY];

  // A write landing on the frame_start cycle bypasses the shadow and applies at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= CFG_RST;
      cfg_out     <= CFG_RST;
      cfg_pending <= 1'b0;
    end else if (frame_start) begin
      if (cfg_wr) begin
        shadow      <= cfg_in;
        cfg_out     <= cfg_in;
        cfg_pending <= 1'b0;
      end else if (cfg_pending) begin
        cfg_out     <= shadow;
        cfg_pending <= 1'b0;
      end
    end else if (cfg_wr) begin
      shadow      <= cfg_in;
      cfg_pending <= 1'b1;
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  logic seen_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= '0;
      seen_first <= 1'b0;
    end else if (frame_start) begin
      seen_first <= 1'b1;
      if (seen_first) frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a 14x8 raster, with PIPE_DLY 0 and 3 instances side by side.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [7:0]  cfg_in;
  logic        cfg_wr;

  logic [10:0] x0, x3;
  logic [9:0]  y0, y3;
  logic        hs0, vs0, de0, ls0, fs0, pend0;
  logic        hs3, vs3, de3, ls3, fs3, pend3;
  logic [7:0]  cfg0, cfg3;
  logic [1:0]  fc0, fc3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VIS(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0),
    .CFG_W(8), .CFG_RST(8'hA5), .FRAME_W(2)
  ) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .cfg_in(cfg_in), .cfg_wr(cfg_wr),
    .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .de(de0),
    .line_start(ls0), .frame_start(fs0), .cfg_out(cfg0),
    .cfg_pending(pend0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VIS(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3),
    .CFG_W(8), .CFG_RST(8'hA5), .FRAME_W(2)
  ) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .cfg_in(cfg_in), .cfg_wr(cfg_wr),
    .x(x3), .y(y3), .hsync(hs3), .vsync(vs3), .de(de3),
    .line_start(ls3), .frame_start(fs3), .cfg_out(cfg3),
    .cfg_pending(pend3), .frame_cnt(fc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected delayed sync/de for a pipe of latency lat, n ce edges after reset (14x8 raster).
  task automatic exp_sync(input int n, input int lat, output logic hs, output logic vs, output logic d);
    int p, px, py;
    if (n < lat) begin
      hs = 1'b1; vs = 1'b1; d = 1'b0;
    end else begin
      p  = n - lat;
      px = p % 14;
      py = (p / 14) % 8;
      hs = !(px >= 10 && px <= 12);
      vs = !(py >= 5 && py <= 6);
      d  = (px < 8) && (py < 4);
    end
  endtask

  task automatic chk_all(input int n, input logic cev);
    int ex, ey, efc;
    logic h, v, d;
    ex = n % 14;
    ey = (n / 14) % 8;
    chk("x0", 32'(x0), 32'(ex));
    chk("y0", 32'(y0), 32'(ey));
    chk("x3", 32'(x3), 32'(ex));
    chk("y3", 32'(y3), 32'(ey));
    chk("line_start0", 32'(ls0), 32'(cev && ex == 0));
    chk("frame_start0", 32'(fs0), 32'(cev && ex == 0 && ey == 0));
    chk("frame_start3", 32'(fs3), 32'(cev && ex == 0 && ey == 0));
    exp_sync(n, 1, h, v, d);
    chk("hsync0", 32'(hs0), 32'(h));
    chk("vsync0", 32'(vs0), 32'(v));
    chk("de0", 32'(de0), 32'(d));
    exp_sync(n, 4, h, v, d);
    chk("hsync3", 32'(hs3), 32'(h));
    chk("vsync3", 32'(vs3), 32'(v));
    chk("de3", 32'(de3), 32'(d));
`ifdef VGA_TIMING_FRAMECNT_EN
    efc = (n == 0) ? 0 : ((n - 1) / 112) % 4;
`else
    efc = 0;
`endif
    chk("frame_cnt0", 32'(fc0), 32'(efc));
    chk("frame_cnt3", 32'(fc3), 32'(efc));
  endtask

  task automatic chk_cfg(input string tag, input logic [7:0] ecfg, input logic epend);
    chk({tag, "_cfg0"}, 32'(cfg0), 32'(ecfg));
    chk({tag, "_pend0"}, 32'(pend0), 32'(epend));
    chk({tag, "_cfg3"}, 32'(cfg3), 32'(ecfg));
  endtask

  initial begin
    int de_cnt;
    int last_fs;
    int n;

    rst = 1'b1; ce = 1'b1; cfg_in = 8'h00; cfg_wr = 1'b0;
    step();
    cfg_in = 8'hFF; cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk_all(0, 1'b1);
    chk_cfg("reset", 8'hA5, 1'b0);
    rst = 1'b0;

    // Two free-running frames with config writes at y=2, y=3 and on the second frame_start.
    de_cnt = 0;
    for (int k = 0; k <= 225; k++) begin
      chk_all(k, 1'b1);
      if (k >= 1 && k <= 112 && de0 === 1'b1) de_cnt++;
      if (k == 28)  begin cfg_in = 8'h5A; cfg_wr = 1'b1; end
      if (k == 29)  chk_cfg("wr5A", 8'hA5, 1'b1);
      if (k == 42)  begin cfg_in = 8'h3C; cfg_wr = 1'b1; end
      if (k == 111) chk_cfg("hold", 8'hA5, 1'b1);
      if (k == 113) chk_cfg("apply", 8'h3C, 1'b0);
      if (k == 224) begin
        chk("fs_at_224", 32'(fs0), 32'd1);
        cfg_in = 8'h11; cfg_wr = 1'b1;
      end
      if (k == 225) chk_cfg("through", 8'h11, 1'b0);
      step();
      cfg_wr = 1'b0;
    end
    chk("de_per_frame", 32'(de_cnt), 32'd32);

    // Run to (5,2) and reset mid-frame.
    for (int k = 226; k < 257; k++) begin
      chk_all(k, 1'b1);
      step();
    end
    chk("pre_rst_x", 32'(x0), 32'd5);
    chk("pre_rst_y", 32'(y0), 32'd2);
    chk("pre_rst_de3", 32'(de3), 32'd1);
    rst = 1'b1;
    step();
    chk_all(0, 1'b1);
    chk_cfg("midrst", 8'hA5, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all(k, 1'b1);
    end

    // ce toggling 1/0 every clk: positions advance on ce edges only.
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    last_fs = -1;
    for (int c = 0; c < 460; c++) begin
      ce = (c % 2 == 0);
      #1;
      chk_all(n, ce);
      if (fs0 === 1'b1) begin
        if (last_fs >= 0) chk("frame_period", 32'(c - last_fs), 32'd224);
        last_fs = c;
      end
      step();
      if (ce) n++;
    end
    chk("saw_two_frames", 32'(last_fs), 32'd448);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
